// File: rtl/gain_filter_mux.sv
// Time-multiplexed first-order low-pass for unsigned gain streams.
// One shared datapath, one widened accumulator and seeded flag per channel.
module gain_filter_mux #(
  parameter int DATA_WIDTH    = 30,
  parameter int SHIFT_WIDTH   = 3,
  parameter int CHANNEL_COUNT = 4,
  parameter int CHANNEL_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SHIFT_WIDTH-1:0]   filterShift,
  input  logic                     seedEnable,
  input  logic                     clear,
  input  logic                     S_TVALID,
  input  logic [DATA_WIDTH-1:0]    S_TDATA,
  input  logic [CHANNEL_WIDTH-1:0] S_TUSER,
  output logic                     M_TVALID,
  output logic [DATA_WIDTH-1:0]    M_TDATA,
  output logic [CHANNEL_WIDTH-1:0] M_TUSER
);

  localparam int WIDEN     = (1 << SHIFT_WIDTH) - 1;
  localparam int SUM_WIDTH = DATA_WIDTH + WIDEN;

  logic [DATA_WIDTH-1:0]    x_r;
  logic [CHANNEL_WIDTH-1:0] ch_r;
  logic [SHIFT_WIDTH-1:0]   shift_r;
  logic                     v1_r;
  logic [SUM_WIDTH-1:0]     acc_r [CHANNEL_COUNT];
  logic [CHANNEL_COUNT-1:0] seeded_r;

  logic                     ch_ok_s;
  logic [SUM_WIDTH-1:0]     acc_cur_s;
  logic [SUM_WIDTH-1:0]     x_wide_s;
  logic [SUM_WIDTH-1:0]     new_s;
  logic [SHIFT_WIDTH-1:0]   up_shift_s;

  // Stage-2 arithmetic, kept at full accumulator width until the output slice
  always_comb begin
    ch_ok_s    = (32'(S_TUSER) < 32'(CHANNEL_COUNT));
    acc_cur_s  = acc_r[ch_r];
    x_wide_s   = SUM_WIDTH'(x_r);
    up_shift_s = SHIFT_WIDTH'(WIDEN) - shift_r;
    new_s      = {SUM_WIDTH{1'b0}};
    if (seedEnable && !seeded_r[ch_r]) begin
      new_s = x_wide_s << WIDEN;
    end else begin
      new_s = (x_wide_s << up_shift_s) + (acc_cur_s - (acc_cur_s >> shift_r));
    end
  end

  // Stage 1: capture sample, tag and pole; out-of-range channels are dropped here
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r    <= 1'b0;
      x_r     <= {DATA_WIDTH{1'b0}};
      ch_r    <= {CHANNEL_WIDTH{1'b0}};
      shift_r <= {SHIFT_WIDTH{1'b0}};
    end else if (clear) begin
      v1_r    <= 1'b0;
    end else begin
      v1_r    <= S_TVALID && ch_ok_s;
      x_r     <= S_TDATA;
      ch_r    <= S_TUSER;
      shift_r <= filterShift;
    end
  end

  // Stage 2: accumulator write-back and registered output; clear beats the write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNEL_COUNT; i++) acc_r[i] <= {SUM_WIDTH{1'b0}};
      seeded_r <= {CHANNEL_COUNT{1'b0}};
      M_TVALID <= 1'b0;
      M_TDATA  <= {DATA_WIDTH{1'b0}};
      M_TUSER  <= {CHANNEL_WIDTH{1'b0}};
    end else if (clear) begin
      for (int i = 0; i < CHANNEL_COUNT; i++) acc_r[i] <= {SUM_WIDTH{1'b0}};
      seeded_r <= {CHANNEL_COUNT{1'b0}};
      M_TVALID <= 1'b0;
    end else begin
      M_TVALID <= v1_r;
      if (v1_r) begin
        acc_r[ch_r]    <= new_s;
        seeded_r[ch_r] <= 1'b1;
        M_TDATA        <= new_s[WIDEN +: DATA_WIDTH];
        M_TUSER        <= ch_r;
      end
    end
  end

endmodule

// File: tb/tb_gain_filter_mux.sv
// Scoreboard bench for gain_filter_mux: stimulus pushes expectations,
// a negedge monitor pops and compares data, channel and latency.
module tb_gain_filter_mux;

  localparam int DW = 30;
  localparam int SW = 3;
  localparam int CC = 3;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SW-1:0] filterShift = 3'd0;
  logic          seedEnable = 1'b0;
  logic          clear = 1'b0;
  logic          S_TVALID = 1'b0;
  logic [DW-1:0] S_TDATA = 30'd0;
  logic [CW-1:0] S_TUSER = 2'd0;
  logic          M_TVALID;
  logic [DW-1:0] M_TDATA;
  logic [CW-1:0] M_TUSER;

  typedef struct {
    int     ch;
    longint data;
    int     cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  gain_filter_mux #(
    .DATA_WIDTH(DW), .SHIFT_WIDTH(SW), .CHANNEL_COUNT(CC), .CHANNEL_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .filterShift(filterShift), .seedEnable(seedEnable),
    .clear(clear), .S_TVALID(S_TVALID), .S_TDATA(S_TDATA), .S_TUSER(S_TUSER),
    .M_TVALID(M_TVALID), .M_TDATA(M_TDATA), .M_TUSER(M_TUSER)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: every output pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (M_TVALID === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: actual ch=%0d data=%0d, required no output",
                 M_TUSER, M_TDATA);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("m_tdata", longint'(M_TDATA), e.data);
        chk("m_tuser", longint'(M_TUSER), longint'(e.ch));
        chk("latency_cycle", longint'(cyc), longint'(e.cyc));
      end
    end
  end

  task automatic send(input int ch, input int data, input bit expect_out, input int exp);
    exp_t e;
    @(posedge clk); #1;
    S_TVALID = 1'b1;
    S_TUSER  = CW'(ch);
    S_TDATA  = DW'(data);
    if (expect_out) begin
      e.ch = ch; e.data = longint'(exp); e.cyc = cyc + 2;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      S_TVALID = 1'b0;
    end
  endtask

  initial begin
    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk("reset_m_tvalid", longint'(M_TVALID), 0);
    chk("reset_m_tdata", longint'(M_TDATA), 0);
    chk("reset_m_tuser", longint'(M_TUSER), 0);
    rst = 1'b0;

    // Shift 1, no seed, constant 1000 on ch0
    filterShift = 3'd1; seedEnable = 1'b0;
    send(0, 1000, 1'b1, 500);
    send(0, 1000, 1'b1, 750);
    send(0, 1000, 1'b1, 875);
    send(0, 1000, 1'b1, 937);
    idle(4);

    // Reset for 3 cycles while samples keep arriving
    rst = 1'b1; S_TVALID = 1'b1; S_TUSER = 2'd0; S_TDATA = 30'd1000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_mid_m_tvalid", longint'(M_TVALID), 0);
      chk("rst_mid_m_tdata", longint'(M_TDATA), 0);
    end
    rst = 1'b0; S_TVALID = 1'b0;
    send(0, 1000, 1'b1, 500);
    idle(4);

    // Pass-through on ch2
    filterShift = 3'd0;
    send(2, 7, 1'b1, 7);
    send(2, 123456, 1'b1, 123456);
    send(2, 0, 1'b1, 0);
    idle(4);

    // Seeded start on ch1, shift 3
    seedEnable = 1'b1; filterShift = 3'd3;
    send(1, 4000, 1'b1, 4000);
    send(1, 4000, 1'b1, 4000);
    send(1, 0, 1'b1, 3500);
    idle(4);

    // Clear, then interleaved channels
    seedEnable = 1'b0; filterShift = 3'd1;
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    send(0, 1000, 1'b1, 500);
    send(1, 2000, 1'b1, 1000);
    send(0, 1000, 1'b1, 750);
    send(1, 2000, 1'b1, 1500);
    idle(4);

    // Out-of-range channel: no output and ch0 state untouched
    send(3, 5000, 1'b0, 0);
    idle(4);
    send(0, 1000, 1'b1, 875);
    idle(4);

    // Clear with a sample in stage 1 and another presented: both dropped
    send(0, 1000, 1'b0, 0);
    @(posedge clk); #1;
    clear = 1'b1; S_TVALID = 1'b1; S_TUSER = 2'd0; S_TDATA = 30'd999;
    @(posedge clk); #1;
    clear = 1'b0; S_TVALID = 1'b0;
    send(0, 1000, 1'b1, 500);
    idle(6);

    chk("scoreboard_drained", longint'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gain_filter_mux.md
Name: gain_filter_mux

Overview:
Time-multiplexed, multi-channel first-order low-pass for unsigned gain/magnitude streams. Each channel has a pole at z = 1 - 2^-filterShift. One shared arithmetic datapath serves all channels, with per-channel accumulator state. Adds synchronous reset, a runtime clear, optional seeding of the first sample, and channel tagging. Sits between per-channel magnitude/gain producers and the AGC/readout logic.

Parameters:
DATA_WIDTH, 30, width of input and output samples (unsigned)
SHIFT_WIDTH, 3, width of filterShift; WIDEN = 2^SHIFT_WIDTH - 1 extra accumulator LSBs
CHANNEL_COUNT, 4, number of independent filter channels (>= 1)
CHANNEL_WIDTH, 2, width of channel tag; must satisfy 2^CHANNEL_WIDTH >= CHANNEL_COUNT

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
filterShift  in  SHIFT_WIDTH  pole selector; 0 = pass-through
seedEnable  in  1  1: first sample per channel after reset/clear loads the accumulator directly
clear  in  1  synchronous: zero all accumulators and seeded flags, flush pipeline
S_TVALID  in  1  input sample valid (no backpressure; always accepted)
S_TDATA  in  DATA_WIDTH  unsigned input sample
S_TUSER  in  CHANNEL_WIDTH  channel index of input sample
M_TVALID  out  1  output sample valid, single-cycle pulse per accepted sample
M_TDATA  out  DATA_WIDTH  filtered value of channel M_TUSER
M_TUSER  out  CHANNEL_WIDTH  channel index of output sample

Behaviour:
- Reset (rst=1 at an edge): M_TVALID=0, M_TDATA=0, M_TUSER=0, all accumulators=0, all seeded flags=0, stage-1 valid=0. rst has priority over clear and over S_TVALID.
- Accumulator per channel: SUM_WIDTH = DATA_WIDTH + WIDEN bits, unsigned. Storage: register array or distributed RAM, one entry per channel.
- Stage 1 (edge after S_TVALID=1): capture x=S_TDATA, ch=S_TUSER, s=filterShift, and v1=1.
  - Samples with S_TUSER >= CHANNEL_COUNT are discarded: v1=0, no output, no state change.
- Stage 2 (next edge, if v1): compute new = (x << (WIDEN - s)) + (acc[ch] - (acc[ch] >> s)).
  - Seed case: if seedEnable=1 and seeded[ch]=0, new = x << WIDEN instead, and seeded[ch] is set.
  - seeded[ch] is also set on a normal update when seedEnable=0.
  - Write acc[ch] = new; M_TDATA = new[WIDEN +: DATA_WIDTH]; M_TUSER = ch; M_TVALID = 1.
- Latency is exactly 2 clocks from S_TVALID to M_TVALID. Throughput is 1 sample/clock. M_TVALID=0 in any cycle with no stage-2 work; M_TDATA/M_TUSER hold their last values.
- Back-to-back samples on the same channel need no hazard logic: the stage-2 write and the next stage-1 capture land on the same edge, so the following compute reads the updated acc.
- filterShift is sampled per sample at stage 1. A change affects only samples accepted after it.
- No overflow: acc is bounded by (2^DATA_WIDTH - 1) << WIDEN for any s. The arithmetic must be done at full SUM_WIDTH, with no truncation before the output slice.
- clear=1 at an edge:
  - zero all acc and seeded flags; v1=0; M_TVALID=0 next cycle;
  - a sample presented with S_TVALID in the same cycle is dropped;
  - a sample in stage 1 is dropped (no output);
  - clear wins over the stage-2 write.
- seedEnable is sampled in stage 2. Toggling it does not retroactively alter seeded flags.

Test Plan:
- rst held 3 cycles mid-stream with S_TVALID=1 -> M_TVALID=0 and M_TDATA=0 throughout; the first sample after deassert behaves as from zero state.
- seedEnable=0, filterShift=1, ch0, constant S_TDATA=1000 each cycle -> M_TDATA 500, 750, 875, 937, exactly 2 cycles after each input, M_TUSER=0.
- filterShift=0, ch2, inputs 7, 123456, 0 -> outputs 7, 123456, 0 (pure pass-through, 2-cycle latency).
- seedEnable=1, filterShift=3, ch1 S_TDATA=4000 twice -> outputs 4000, 4000; then 0 -> 3500.
- Interleaved ch0=1000 / ch1=2000, seedEnable=0, filterShift=1 -> outputs ch0:500, ch1:1000, ch0:750, ch1:1500; channels independent.
- CHANNEL_COUNT=3, S_TUSER=3 -> no M_TVALID, no state change. Clear asserted with ch0 acc nonzero and a sample in stage 1 -> that sample is dropped; the next ch0 input 1000 (shift 1, no seed) yields 500.
